fft_frame_feeder: RTL and testbench

Framing front end that drives the sink side of the 8-point variable-size FFT core. Continuous complex samples are buffered in a 16-entry FIFO. Once a full frame is available, the block emits it as an Avalon-ST packet with `sop`/`eop` and a constant `fftpts`/`inverse`, honoring the core's `sink_ready` backpressure. It sits between the sample source (ADC/mixer path) and the FFT core's `sink_*` ports.

---
 rtl/fft_frame_feeder_if.sv | 35 +++
 rtl/fft_frame_feeder.sv | 178 +++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_if.sv
`default_nettype none
// ============================================================================
// fft_frame_feeder_if : Avalon-ST sink bus toward the FFT core plus the
//                       per-frame side-band (fftpts / inverse).
// Revision 1.0
// ============================================================================
interface fft_frame_feeder_if #(
  parameter int DATA_W = 16,
  parameter int PTS_W  = 4
);
  logic              fft_sink_valid;
  logic              fft_sink_ready;
  logic              fft_sink_sop;
  logic              fft_sink_eop;
  logic [DATA_W-1:0] fft_sink_real;
  logic [DATA_W-1:0] fft_sink_imag;
  logic [1:0]        fft_sink_error;
  logic [PTS_W-1:0]  fft_fftpts;
  logic              fft_inverse;

  modport master (
    output fft_sink_valid, fft_sink_sop, fft_sink_eop,
    output fft_sink_real, fft_sink_imag, fft_sink_error,
    output fft_fftpts, fft_inverse,
    input  fft_sink_ready
  );

  modport slave (
    input  fft_sink_valid, fft_sink_sop, fft_sink_eop,
    input  fft_sink_real, fft_sink_imag, fft_sink_error,
    input  fft_fftpts, fft_inverse,
    output fft_sink_ready
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// fft_frame_feeder : buffers a continuous complex sample stream and emits
//                    N-point frames as Avalon-ST packets to an FFT core sink.
// Revision 1.0
// ============================================================================
module fft_frame_feeder #(
  parameter int DATA_W  = 16,
  parameter int MAX_PTS = 8,
  parameter int PTS_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PTS_W-1:0]   cfg_pts,
  input  logic               cfg_inverse,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_real,
  input  logic [DATA_W-1:0]  in_imag,
  fft_frame_feeder_if.master sink,
  output logic               busy,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic [15:0]        frame_cnt
);

  localparam int DEPTH = 2 * MAX_PTS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [PTS_W-1:0] PTS_MAX = PTS_W'(MAX_PTS);
  localparam logic [PTS_W-1:0] PTS_ONE = PTS_W'(1);
  localparam logic [PTS_W-1:0] PTS_TWO = PTS_W'(2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic [0:0]          state;
  logic [0:0]          next_state;
  logic                start;
  logic                pop;

  logic [PTS_W-1:0]    n_req;
  logic [PTS_W-1:0]    fftpts_r;
  logic                inverse_r;
  logic [PTS_W-1:0]    k;
  logic                last_word;

  logic                valid_r;
  logic                sop_r;
  logic                eop_r;
  logic [DATA_W-1:0]   real_r;
  logic [DATA_W-1:0]   imag_r;

  logic                wr_en;
  logic                drop;
  logic                out_free;

  // Anything that is not a power of two in [2, MAX_PTS] falls back to MAX_PTS.
  always_comb begin
    n_req = PTS_MAX;
    if ((cfg_pts >= PTS_TWO) && (cfg_pts <= PTS_MAX) &&
        ((cfg_pts & (cfg_pts - PTS_ONE)) == '0)) begin
      n_req = cfg_pts;
    end
  end

  assign wr_en     = in_valid && (count != FULL);
  assign drop      = in_valid && (count == FULL);
  assign out_free  = !valid_r || sink.fft_sink_ready;
  assign last_word = (k == (fftpts_r - PTS_ONE));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_imag, in_real};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)            next_state = S_SEND;
      S_SEND:  if (pop && last_word) next_state = S_IDLE;
      default:                       next_state = S_IDLE;
    endcase
  end

  // Holding off the start while a stalled word is pending keeps fftpts/inverse
  // stable under the previous frame's unaccepted eop.
  always_comb begin
    start = 1'b0;
    pop   = 1'b0;
    case (state)
      S_IDLE:  start = enable && out_free && (32'(count) >= 32'(n_req));
      S_SEND:  pop   = out_free && (count != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fftpts_r  <= PTS_MAX;
      inverse_r <= 1'b0;
      k         <= '0;
    end else if (start) begin
      fftpts_r  <= n_req;
      inverse_r <= cfg_inverse;
      k         <= '0;
    end else if (pop) begin
      k         <= k + PTS_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      real_r  <= '0;
      imag_r  <= '0;
    end else if (pop) begin
      valid_r          <= 1'b1;
      sop_r            <= (k == '0);
      eop_r            <= last_word;
      {imag_r, real_r} <= mem[rd_ptr];
    end else if (sink.fft_sink_ready) begin
      valid_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (valid_r && sink.fft_sink_ready && eop_r) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign busy                = (state == S_SEND) || valid_r;
  assign sink.fft_sink_valid = valid_r;
  assign sink.fft_sink_sop   = sop_r;
  assign sink.fft_sink_eop   = eop_r;
  assign sink.fft_sink_real  = real_r;
  assign sink.fft_sink_imag  = imag_r;
  assign sink.fft_sink_error = 2'b00;
  assign sink.fft_fftpts     = fftpts_r;
  assign sink.fft_inverse    = inverse_r;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_feeder : self-checking bench for fft_frame_feeder.
// Revision 1.0
// ============================================================================
module tb_fft_frame_feeder;

  localparam int DATA_W  = 16;
  localparam int MAX_PTS = 8;
  localparam int PTS_W   = 4;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sop;
    logic        eop;
    logic [3:0]  pts;
    logic        inv;
  } word_t;

  typedef struct {
    logic [3:0] cfg;
    logic       inv;
    int         exp_n;
  } cfg_vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [PTS_W-1:0]  cfg_pts;
  logic              cfg_inverse;
  logic              in_valid;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              busy;
  logic              overflow;
  logic              ovf_clr;
  logic [15:0]       frame_cnt;

  fft_frame_feeder_if #(.DATA_W(DATA_W), .PTS_W(PTS_W)) sink ();

  fft_frame_feeder #(.DATA_W(DATA_W), .MAX_PTS(MAX_PTS), .PTS_W(PTS_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_pts     (cfg_pts),
    .cfg_inverse (cfg_inverse),
    .in_valid    (in_valid),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .sink        (sink),
    .busy        (busy),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int       checks   = 0;
  int       failures = 0;
  int       cyc      = 0;
  int       rdy_mode = 0;
  logic     prev_hold = 1'b0;
  word_t    prev_w;
  word_t    acc_q[$];
  word_t    exp_q[$];
  int       sop_cyc[$];
  int       eop_cyc[$];
  cfg_vec_t vecs[8];
  logic [3:0] cfg_list[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t cur_word();
    return {sink.fft_sink_real, sink.fft_sink_imag, sink.fft_sink_sop,
            sink.fft_sink_eop, sink.fft_fftpts, sink.fft_inverse};
  endfunction

  // Advance one clock, pick this cycle's ready, then log handshakes and holds.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       sink.fft_sink_ready = 1'b1;
      1:       sink.fft_sink_ready = cyc[0];
      2:       sink.fft_sink_ready = ($urandom_range(0, 3) != 0);
      default: sink.fft_sink_ready = 1'b0;
    endcase
    if (prev_hold) check("hold_stable", {sink.fft_sink_valid, cur_word()}, {1'b1, prev_w});
    if (sink.fft_sink_valid && sink.fft_sink_ready) begin
      acc_q.push_back(cur_word());
      if (sink.fft_sink_sop) sop_cyc.push_back(cyc);
      if (sink.fft_sink_eop) eop_cyc.push_back(cyc);
    end
    prev_hold = sink.fft_sink_valid && !sink.fft_sink_ready;
    prev_w    = cur_word();
  endtask

  task automatic settle(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_logs();
    acc_q.delete();
    exp_q.delete();
    sop_cyc.delete();
    eop_cyc.delete();
    prev_hold = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic drive(input int v);
    in_valid = 1'b1;
    in_real  = 16'(v);
    in_imag  = 16'(-v);
  endtask

  task automatic push_run(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      drive(first + i);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  // Reference: a frame is n consecutive samples, sop on the first, eop on the last.
  task automatic add_exp(input int first, input int n, input logic inv);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.re  = 16'(first + i);
      w.im  = 16'(-(first + i));
      w.sop = (i == 0);
      w.eop = (i == n - 1);
      w.pts = 4'(n);
      w.inv = inv;
      exp_q.push_back(w);
    end
  endtask

  task automatic drain(input int n, input int limit, input string name);
    int t;
    t = 0;
    while (acc_q.size() < n && t < limit) begin
      cycle();
      t++;
    end
    if (acc_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=%0d words expected=%0d words", name, acc_q.size(), n);
    end
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, 64'(acc_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) check(name, acc_q[i], exp_q[i]);
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    int frames;
    int base;
    logic inv;

    vecs[0] = '{4'd0,  1'b0, 8};
    vecs[1] = '{4'd1,  1'b1, 8};
    vecs[2] = '{4'd2,  1'b0, 2};
    vecs[3] = '{4'd3,  1'b1, 8};
    vecs[4] = '{4'd4,  1'b1, 4};
    vecs[5] = '{4'd5,  1'b0, 8};
    vecs[6] = '{4'd8,  1'b1, 8};
    vecs[7] = '{4'd15, 1'b0, 8};
    cfg_list[0] = 4'd2;
    cfg_list[1] = 4'd4;
    cfg_list[2] = 4'd8;
    cfg_list[3] = 4'd5;

    reset = 1'b1; enable = 1'b0; cfg_pts = 4'd8; cfg_inverse = 1'b0;
    in_valid = 1'b0; in_real = '0; in_imag = '0; ovf_clr = 1'b0;
    sink.fft_sink_ready = 1'b1;

    // Reset state
    do_reset();
    check("reset_zero", {sink.fft_sink_valid, sink.fft_sink_sop, sink.fft_sink_eop,
                         sink.fft_sink_real, sink.fft_sink_imag, sink.fft_sink_error,
                         sink.fft_inverse, busy, overflow, frame_cnt}, '0);
    check("reset_fftpts", sink.fft_fftpts, 8);

    // Basic frame with exact startup latency
    enable = 1'b1; cfg_pts = 4'd8; rdy_mode = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(i);
      if (i < 8) cycle();
    end
    cycle();
    in_valid = 1'b0;
    cycle();
    check("basic_idle_c2", sink.fft_sink_valid, 0);
    cycle();
    check("basic_sop_c3", {sink.fft_sink_valid, sink.fft_sink_sop, busy}, 3'b111);
    check("basic_fftpts", sink.fft_fftpts, 8);
    settle(7);
    check("basic_cnt_pre", frame_cnt, 0);
    cycle();
    check("basic_cnt", frame_cnt, 1);
    add_exp(1, 8, 1'b0);
    compare_stream("basic");

    // Back-to-back N=4 frames with a single-cycle gap
    do_reset();
    cfg_pts = 4'd4;
    push_run(1, 12);
    drain(12, 60, "b2b");
    check("b2b_nsop", 64'(sop_cyc.size()), 3);
    check("b2b_neop", 64'(eop_cyc.size()), 3);
    for (int f = 1; f < 3 && f < sop_cyc.size() && f <= eop_cyc.size(); f++)
      check("b2b_gap", 64'(sop_cyc[f] - eop_cyc[f-1]), 2);
    cycle();
    check("b2b_cnt", frame_cnt, 3);
    settle(3);
    for (int f = 0; f < 3; f++) add_exp(1 + 4*f, 4, 1'b0);
    compare_stream("b2b");

    // Backpressure with ready toggling every cycle
    do_reset();
    cfg_pts = 4'd8; rdy_mode = 1;
    push_run(1, 8);
    drain(8, 80, "bp");
    settle(3);
    add_exp(1, 8, 1'b0);
    compare_stream("bp");
    rdy_mode = 0;

    // Overflow: fill with no frame started, drop 17th, then drop during a read
    do_reset();
    enable = 1'b0;
    for (int v = 1; v <= 17; v++) begin
      if (v == 17) check("ovf_not_yet", overflow, 0);
      drive(v);
      cycle();
    end
    in_valid = 1'b0;
    check("ovf_set", {overflow, sink.fft_sink_valid}, 2'b10);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    enable = 1'b1;
    cycle();
    drive(99);
    ovf_clr = 1'b1;
    cycle();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    check("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("ovf_clr2", overflow, 0);
    drain(16, 60, "ovf");
    cycle();
    check("ovf_cnt", frame_cnt, 2);
    settle(4);
    add_exp(1, 8, 1'b0);
    add_exp(9, 8, 1'b0);
    compare_stream("ovf");

    // Config decode table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cfg_pts = vecs[i].cfg; cfg_inverse = vecs[i].inv; enable = 1'b1;
      push_run(16*i + 1, vecs[i].exp_n);
      drain(vecs[i].exp_n, 40, "cfg");
      settle(4);
      add_exp(16*i + 1, vecs[i].exp_n, vecs[i].inv);
      compare_stream("cfg_vec");
    end

    // Mid-frame config change applies to the next frame only
    do_reset();
    cfg_pts = 4'd8; cfg_inverse = 1'b0;
    push_run(1, 10);
    cfg_pts = 4'd2; cfg_inverse = 1'b1;
    drain(10, 60, "midcfg");
    settle(4);
    add_exp(1, 8, 1'b0);
    add_exp(9, 2, 1'b1);
    compare_stream("midcfg");
    cfg_pts = 4'd8; cfg_inverse = 1'b0;

    // Enable gating
    do_reset();
    enable = 1'b0;
    push_run(1, 8);
    settle(12);
    check("en0_no_words", 64'(acc_q.size()), 0);
    check("en0_not_busy", busy, 0);
    enable = 1'b1;
    drain(1, 20, "en1");
    enable = 1'b0;
    drain(8, 40, "en_mid");
    push_run(9, 8);
    settle(12);
    add_exp(1, 8, 1'b0);
    compare_stream("en_frame");

    // Reset mid-frame truncates and flushes
    do_reset();
    enable = 1'b1;
    push_run(1, 8);
    drain(8, 40, "pre_rst");
    cycle();
    check("pre_rst_cnt", frame_cnt, 1);
    clear_logs();
    push_run(9, 8);
    drain(3, 40, "rst_mid");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid_out", {sink.fft_sink_valid, busy, frame_cnt}, '0);
    clear_logs();
    push_run(100, 7);
    settle(15);
    check("rst_mid_flush", 64'(acc_q.size()), 0);
    push_run(107, 1);
    drain(8, 40, "rst_post");
    settle(3);
    add_exp(100, 8, 1'b0);
    compare_stream("rst_post");

    // Randomized traffic against the frame-chunking reference
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      cfg_pts     = cfg_list[ph];
      inv         = 1'($urandom_range(0, 1));
      cfg_inverse = inv;
      n           = (cfg_list[ph] inside {4'd2, 4'd4, 4'd8}) ? int'(cfg_list[ph]) : 8;
      base        = 1 + 500*ph;
      sent        = 0;
      rdy_mode    = 2;
      for (int t = 0; t < 200; t++) begin
        if ((sent - acc_q.size()) < 14 && $urandom_range(0, 1) == 1) begin
          drive(base + sent);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
        enable = ($urandom_range(0, 3) != 0);
        cycle();
      end
      in_valid = 1'b0;
      enable   = 1'b1;
      frames   = sent / n;
      drain(frames * n, 400, "rand");
      cycle();
      check("rand_cnt", frame_cnt, 64'(frames));
      settle(4);
      check("rand_no_ovf", overflow, 0);
      for (int f = 0; f < frames; f++) add_exp(base + f*n, n, inv);
      compare_stream("rand");
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
